// File: rtl/cache_pkg.sv
// cache_pkg: fill-engine state encoding, fill-target selects and line-offset width helper
package cache_pkg;
  typedef enum logic [1:0] {IDLE, REQ, DRAIN, DONE} state_t;
  localparam logic SEL_I = 1'b0;
  localparam logic SEL_D = 1'b1;
  function automatic int off_w(input int line_words);
    return $clog2(line_words) + 1;
  endfunction
endpackage

// File: rtl/fill_word_counter.sv
// fill_word_counter: wrapping word-offset counter; last flags the offset just before wrapping back to start
module fill_word_counter #(
  parameter int WORDS = 8,
  parameter int CW = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] start,
  input  logic          inc,
  output logic [CW-1:0] value,
  output logic          last
);
  logic [CW-1:0] start_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value   <= '0;
      start_q <= '0;
    end else if (load) begin
      value   <= start;
      start_q <= start;
    end else if (inc) begin
      value   <= value + CW'(1);
    end
  end
  assign last = (value + CW'(1)) == start_q;
endmodule

// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: arbitrates I/D line misses and streams line fills from shared memory.
// Define CRITICAL_WORD_FIRST_EN to start each fill at the missed word and add crit_valid.
module cache_fill_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int WORD_W      = 16,
  parameter int LINE_WORDS  = 8,
  parameter int MEM_LATENCY = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_miss,
  input  logic [ADDR_W-1:0]             i_miss_addr,
  input  logic                          d_miss,
  input  logic [ADDR_W-1:0]             d_miss_addr,
  output logic                          mem_en,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic                          mem_valid,
  input  logic [WORD_W-1:0]             mem_rdata,
  output logic                          fill_we,
  output logic                          fill_sel,
  output logic [$clog2(LINE_WORDS)-1:0] fill_idx,
  output logic [WORD_W-1:0]             fill_data,
  output logic [ADDR_W-1:0]             fill_line_addr,
  output logic                          fill_tag_we,
  output logic                          i_done,
  output logic                          d_done,
  output logic                          busy
`ifdef CRITICAL_WORD_FIRST_EN
  ,
  output logic                          crit_valid
`endif
);
  localparam int CW  = $clog2(LINE_WORDS);
  localparam int OFF = off_w(LINE_WORDS);
  if (MEM_LATENCY < 1 || LINE_WORDS < 2 || (1 << CW) != LINE_WORDS) begin : g_bad_cfg
    $error("cache_fill_ctrl: unsupported LINE_WORDS/MEM_LATENCY");
  end
  state_t            state, state_nx;
  logic              sel, load, req_last, rsp_last, rsp_fin;
  logic [ADDR_W-1:0] base, miss_addr;
  logic [CW-1:0]     start, req_val, rsp_val;
  assign miss_addr = d_miss ? d_miss_addr : i_miss_addr;
  assign load      = state == IDLE && (i_miss || d_miss);
  assign mem_en    = state == REQ;
  // Responses only count while a fill is collecting data; stale or surplus ones fall away.
  assign fill_we   = mem_valid && (state == REQ || state == DRAIN);
  assign rsp_fin   = fill_we && rsp_last;
`ifdef CRITICAL_WORD_FIRST_EN
  logic [CW-1:0] crit_off;
  assign start      = miss_addr[OFF-1:1];
  assign crit_valid = fill_we && rsp_val == crit_off;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) crit_off <= '0;
    else if (load) crit_off <= start;
  end
`else
  assign start = '0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sel   <= SEL_I;
      base  <= '0;
    end else begin
      state <= state_nx;
      if (load) begin
        sel  <= d_miss ? SEL_D : SEL_I;
        base <= miss_addr & ~ADDR_W'((1 << OFF) - 1);
      end
    end
  end
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  state_nx = (i_miss || d_miss) ? REQ : IDLE;
      REQ:   state_nx = rsp_fin ? DONE : req_last ? DRAIN : REQ;
      DRAIN: state_nx = rsp_fin ? DONE : DRAIN;
      DONE:  state_nx = IDLE;
    endcase
  end
  fill_word_counter #(.WORDS(LINE_WORDS)) u_req (
    .clk(clk), .rst(rst), .load(load), .start(start), .inc(mem_en), .value(req_val), .last(req_last)
  );
  fill_word_counter #(.WORDS(LINE_WORDS)) u_rsp (
    .clk(clk), .rst(rst), .load(load), .start(start), .inc(fill_we), .value(rsp_val), .last(rsp_last)
  );
  assign mem_addr       = mem_en ? base + ADDR_W'({req_val, 1'b0}) : '0;
  assign fill_sel       = sel;
  assign fill_idx       = fill_we ? rsp_val : '0;
  assign fill_data      = fill_we ? mem_rdata : '0;
  assign fill_line_addr = base;
  assign fill_tag_we    = state == DONE;
  assign i_done         = fill_tag_we && sel == SEL_I;
  assign d_done         = fill_tag_we && sel == SEL_D;
  assign busy           = state != IDLE;
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb_cache_fill_ctrl: directed and random miss traffic against a fill-timeline reference model
module tb_cache_fill_ctrl;
  localparam int ADDR_W = 16, WORD_W = 16, L = 8, LAT = 4, CW = 3;
  localparam int DN = L + LAT + 1;
  logic clk = 1'b0, rst;
  logic i_miss, d_miss, mem_en, mem_valid, fill_we, fill_sel, fill_tag_we, i_done, d_done, busy;
  logic [ADDR_W-1:0] i_miss_addr, d_miss_addr, mem_addr, fill_line_addr;
  logic [WORD_W-1:0] mem_rdata, fill_data;
  logic [CW-1:0] fill_idx;
`ifdef CRITICAL_WORD_FIRST_EN
  logic crit_valid;
`endif
  always #5 clk = ~clk;
  cache_fill_ctrl #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .LINE_WORDS(L), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .i_miss(i_miss), .i_miss_addr(i_miss_addr), .d_miss(d_miss),
    .d_miss_addr(d_miss_addr), .mem_en(mem_en), .mem_addr(mem_addr), .mem_valid(mem_valid),
    .mem_rdata(mem_rdata), .fill_we(fill_we), .fill_sel(fill_sel), .fill_idx(fill_idx),
    .fill_data(fill_data), .fill_line_addr(fill_line_addr), .fill_tag_we(fill_tag_we),
    .i_done(i_done), .d_done(d_done), .busy(busy)
`ifdef CRITICAL_WORD_FIRST_EN
    , .crit_valid(crit_valid)
`endif
  );
  typedef struct {int due; logic [WORD_W-1:0] d;} rsp_t;
  rsp_t q[$];
  int checks = 0, errors = 0, cyc = 0;
  int j_t0, j_s, d_done_at, i_done_at, c0;
  bit job_on, set_i, set_d, drop_i, drop_d, spur;
  logic j_sel, exp_sel;
  logic [ADDR_W-1:0] j_base, exp_line, ai, ad;
  function automatic logic [WORD_W-1:0] fdat(input logic [ADDR_W-1:0] a);
    return WORD_W'(32'(a) * 32'd37 + 32'd437);
  endfunction
  function automatic bit m_idle();
    return !job_on || (cyc - j_t0) > DN;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_mem_en"}, mem_en, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_fill_we"}, fill_we, 0);
    chk({tag, "_fill_idx"}, fill_idx, 0);
    chk({tag, "_tag_we"}, fill_tag_we, 0);
    chk({tag, "_done"}, {i_done, d_done}, 0);
    chk({tag, "_line"}, fill_line_addr, 0);
    chk({tag, "_sel"}, fill_sel, 0);
  endtask
  task automatic step();
    int r, k, off;
    bit act, en, we;
    logic [ADDR_W-1:0] a;
    rsp_t e;
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    r = cyc - j_t0;
    if (job_on && r == DN + 1) begin
      if (j_sel) d_miss = 1'b0;
      else i_miss = 1'b0;
    end
    if (drop_i) i_miss = 1'b0;
    if (drop_d) d_miss = 1'b0;
    if (set_i) begin i_miss = 1'b1; i_miss_addr = ai; end
    if (set_d) begin d_miss = 1'b1; d_miss_addr = ad; end
    {set_i, set_d, drop_i, drop_d} = '0;
    mem_valid = 1'b0;
    mem_rdata = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      mem_valid = 1'b1;
      mem_rdata = e.d;
    end else if (spur && !(job_on && r >= 1 && r <= L + LAT) && $urandom_range(3) == 0) begin
      mem_valid = 1'b1;
      mem_rdata = WORD_W'($urandom);
    end
    @(negedge clk);
    act = job_on && r >= 1 && r <= DN;
    en  = act && r <= L;
    we  = act && r > LAT && r <= LAT + L;
    k   = r - LAT - 1;
    chk("busy", busy, act);
    chk("mem_en", mem_en, en);
    if (en) begin
      off = (j_s + r - 1) % L;
      chk("mem_addr", mem_addr, j_base + ADDR_W'(2 * off));
    end else chk("mem_addr_idle", mem_addr, 0);
    chk("fill_we", fill_we, we);
    if (we) begin
      off = (j_s + k) % L;
      chk("fill_idx", fill_idx, off);
      chk("fill_data", fill_data, fdat(j_base + ADDR_W'(2 * off)));
    end else chk("fill_data_idle", fill_data, 0);
`ifdef CRITICAL_WORD_FIRST_EN
    chk("crit_valid", crit_valid, we && k == 0);
`endif
    chk("fill_tag_we", fill_tag_we, act && r == DN);
    chk("i_done", i_done, act && r == DN && !j_sel);
    chk("d_done", d_done, act && r == DN && j_sel);
    chk("fill_sel", fill_sel, exp_sel);
    chk("fill_line_addr", fill_line_addr, exp_line);
    if (mem_en) q.push_back('{due: cyc + LAT, d: fdat(mem_addr)});
    if (d_done) d_done_at = cyc;
    if (i_done) i_done_at = cyc;
    if (m_idle() && (d_miss || i_miss)) begin
      a      = d_miss ? d_miss_addr : i_miss_addr;
      job_on = 1'b1;
      j_t0   = cyc;
      j_sel  = d_miss;
      j_base = a & ~ADDR_W'(2 * L - 1);
`ifdef CRITICAL_WORD_FIRST_EN
      j_s = int'(a[CW:1]);
`else
      j_s = 0;
`endif
      exp_sel  = j_sel;
      exp_line = j_base;
    end
  endtask
  task automatic drain();
    int n = 0;
    do begin
      step();
      n++;
    end while (!(m_idle() && !i_miss && !d_miss && q.size() == 0) && n < 300);
    checks++;
    assert (n < 300) else begin
      errors++;
      $error("FAIL drain_bound: observed %0d cycles expected < 300", n);
    end
  endtask
  task automatic do_reset();
    #1 rst = 1'b1;
    #1 check_zero("async_rst");
    job_on = 1'b0;
    exp_line = '0;
    exp_sel = 1'b0;
    i_miss = 1'b0;
    d_miss = 1'b0;
  endtask
  initial begin
    {i_miss, d_miss, mem_valid} = '0;
    {i_miss_addr, d_miss_addr, mem_rdata, ai, ad, j_base, exp_line} = '0;
    {set_i, set_d, drop_i, drop_d, job_on, j_sel, exp_sel} = '0;
    {j_t0, j_s, d_done_at, i_done_at} = '0;
    spur = 1'b1;
    rst = 1'b0;
    #2 rst = 1'b1;
    #2 check_zero("reset");
    repeat (3) step();
    // single D miss
    set_d = 1'b1; ad = 16'h1236; c0 = cyc + 1;
    drain();
    chk("d_done_cycle", d_done_at - c0, DN);
    // simultaneous misses: D first, I right after the IDLE cycle
    set_d = 1'b1; ad = 16'h2468; set_i = 1'b1; ai = 16'h0A02;
    drain();
    chk("done_gap", i_done_at - d_done_at, DN + 1);
    // flush drops the miss mid-fill
    set_d = 1'b1; ad = 16'h3000; c0 = cyc + 1;
    repeat (3) step();
    drop_d = 1'b1;
    drain();
    chk("flush_done_cycle", d_done_at - c0, DN);
    // reset in cycle 7, stale responses must not fill
    set_d = 1'b1; ad = 16'h4444;
    repeat (8) step();
    do_reset();
    drain();
    // top-of-memory line
    set_i = 1'b1; ai = 16'hFFFE; c0 = cyc + 1;
    drain();
    chk("wrap_i_done_cycle", i_done_at - c0, DN);
    // mid-line miss
    set_d = 1'b1; ad = 16'h123A;
    drain();
    // random traffic
    for (int it = 0; it < 60; it++) begin
      if (!i_miss && $urandom_range(2) == 0) begin set_i = 1'b1; ai = ADDR_W'($urandom); end
      if (!d_miss && $urandom_range(2) == 0) begin set_d = 1'b1; ad = ADDR_W'($urandom); end
      if ($urandom_range(15) == 0) begin
        drop_i = 1'($urandom_range(1));
        drop_d = !drop_i;
      end
      repeat ($urandom_range(1, 12)) step();
    end
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
